// File: rtl/sprite_move_sequencer_if.sv
// Link between the sprite sequencer and the shared position-update stage:
// one sprite's position/direction out, the stage's settled result back.
interface sprite_move_sequencer_if;
  logic [10:0] upd_pos_x;
  logic [9:0]  upd_pos_y;
  logic [3:0]  upd_dir;
  logic [2:0]  upd_sprite;
  logic        upd_rst;
  logic [10:0] upd_new_x;
  logic [9:0]  upd_new_y;

  modport master (
    output upd_pos_x, upd_pos_y, upd_dir, upd_sprite, upd_rst,
    input  upd_new_x, upd_new_y
  );

  modport slave (
    input  upd_pos_x, upd_pos_y, upd_dir, upd_sprite, upd_rst,
    output upd_new_x, upd_new_y
  );
endinterface

// File: rtl/sprite_move_sequencer.sv
// Game-tick scheduler: owns all five sprite positions and time-multiplexes one
// shared position-update stage, one fixed-length slot per sprite.
module sprite_move_sequencer #(
  parameter int TICK_DIV      = 1250000,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [3:0]                     dir_pacman,
  input  logic [15:0]                    dir_ghosts,
  sprite_move_sequencer_if.master        upd,
  output logic [54:0]                    pos_x,
  output logic [49:0]                    pos_y,
  output logic                           pos_valid,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           tick_overrun
);
  localparam int NUM_SPRITES = 5;
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SUB_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TICK_DIV - 1);
  localparam logic [SUB_W-1:0] SUB_LAST    = SUB_W'(SETTLE_CYCLES);
  localparam logic [2:0]       SPRITE_LAST = 3'(NUM_SPRITES - 1);

  typedef enum logic [1:0] {INIT, WAIT_TICK, SLOT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] tick_cnt_reg;
  logic [SUB_W-1:0] sub_reg, sub_next;
  logic [2:0]       sprite_reg, sprite_next;
  logic             started_reg;
  logic [19:0]      dir_snap_reg;
  logic [10:0]      pos_x_reg [NUM_SPRITES];
  logic [9:0]       pos_y_reg [NUM_SPRITES];
  logic             pos_valid_reg;
  logic             tick_overrun_reg;
  logic             tick;
  logic             in_slot;
  logic             capture;
  logic [10:0]      sel_x;
  logic [9:0]       sel_y;
  logic [3:0]       sel_dir;

  assign tick = (tick_cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst || tick) tick_cnt_reg <= '0;
    else             tick_cnt_reg <= tick_cnt_reg + CNT_W'(1);
  end

  // The cycle right after reset is idle so the init sweep starts one cycle later.
  assign in_slot = (state_reg == SLOT) || (state_reg == INIT && started_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= INIT;
      sub_reg     <= '0;
      sprite_reg  <= '0;
      started_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      sub_reg     <= sub_next;
      sprite_reg  <= sprite_next;
      started_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next  = state_reg;
    sub_next    = sub_reg;
    sprite_next = sprite_reg;
    capture     = 1'b0;
    case (state_reg)
      WAIT_TICK: begin
        if (tick && enable) begin
          state_next  = SLOT;
          sub_next    = '0;
          sprite_next = '0;
        end
      end
      DONE:    state_next = WAIT_TICK;
      default: ;
    endcase
    if (in_slot) begin
      if (sub_reg == SUB_LAST) begin
        capture  = 1'b1;
        sub_next = '0;
        if (sprite_reg == SPRITE_LAST) begin
          state_next  = DONE;
          sprite_next = '0;
        end else begin
          sprite_next = sprite_reg + 3'd1;
        end
      end else begin
        sub_next = sub_reg + SUB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_snap_reg     <= '0;
      pos_valid_reg    <= 1'b0;
      tick_overrun_reg <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        pos_x_reg[i] <= '0;
        pos_y_reg[i] <= '0;
      end
    end else begin
      if (state_reg == WAIT_TICK && tick && enable)
        dir_snap_reg <= {dir_ghosts, dir_pacman};
      if (tick && state_reg != WAIT_TICK)
        tick_overrun_reg <= 1'b1;
      if (state_next == DONE)
        pos_valid_reg <= 1'b1;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (capture && sprite_reg == 3'(i)) begin
          pos_x_reg[i] <= upd.upd_new_x;
          pos_y_reg[i] <= upd.upd_new_y;
        end
      end
    end
  end

  always_comb begin
    sel_x   = '0;
    sel_y   = '0;
    sel_dir = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (sprite_reg == 3'(i)) begin
        sel_x   = pos_x_reg[i];
        sel_y   = pos_y_reg[i];
        sel_dir = dir_snap_reg[4*i +: 4];
      end
    end
  end

  assign upd.upd_pos_x  = sel_x;
  assign upd.upd_pos_y  = sel_y;
  assign upd.upd_dir    = (state_reg == SLOT) ? sel_dir : 4'd0;
  assign upd.upd_sprite = sprite_reg;
  assign upd.upd_rst    = (state_reg == INIT);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_pos
      assign pos_x[11*gi +: 11] = pos_x_reg[gi];
      assign pos_y[10*gi +: 10] = pos_y_reg[gi];
    end
  endgenerate

  assign pos_valid    = pos_valid_reg;
  assign busy         = (state_reg != WAIT_TICK);
  assign frame_done   = (state_reg == DONE);
  assign tick_overrun = tick_overrun_reg;
endmodule

// File: tb/tb_sprite_move_sequencer.sv
// Bench for sprite_move_sequencer: a normal-rate instance and a fast-tick
// (overrunning) instance, both checked against a frame-level reference model.
module tb_sprite_move_sequencer;
  localparam int NI = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        enable;
  logic [3:0]  dir_pacman;
  logic [15:0] dir_ghosts;

  logic [54:0] pos_x_o [NI];
  logic [49:0] pos_y_o [NI];
  logic        valid_o [NI];
  logic        busy_o  [NI];
  logic        done_o  [NI];
  logic        ovr_o   [NI];
  logic [10:0] upx_o   [NI];
  logic [9:0]  upy_o   [NI];
  logic [3:0]  udir_o  [NI];
  logic [2:0]  uspr_o  [NI];
  logic        urst_o  [NI];

  sprite_move_sequencer_if upd_a ();
  sprite_move_sequencer_if upd_b ();

  sprite_move_sequencer #(.TICK_DIV(32), .SETTLE_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .dir_pacman(dir_pacman), .dir_ghosts(dir_ghosts),
    .upd(upd_a), .pos_x(pos_x_o[0]), .pos_y(pos_y_o[0]), .pos_valid(valid_o[0]),
    .busy(busy_o[0]), .frame_done(done_o[0]), .tick_overrun(ovr_o[0])
  );

  sprite_move_sequencer #(.TICK_DIV(10), .SETTLE_CYCLES(2)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .dir_pacman(dir_pacman), .dir_ghosts(dir_ghosts),
    .upd(upd_b), .pos_x(pos_x_o[1]), .pos_y(pos_y_o[1]), .pos_valid(valid_o[1]),
    .busy(busy_o[1]), .frame_done(done_o[1]), .tick_overrun(ovr_o[1])
  );

  assign upx_o[0]  = upd_a.upd_pos_x;
  assign upy_o[0]  = upd_a.upd_pos_y;
  assign udir_o[0] = upd_a.upd_dir;
  assign uspr_o[0] = upd_a.upd_sprite;
  assign urst_o[0] = upd_a.upd_rst;
  assign upx_o[1]  = upd_b.upd_pos_x;
  assign upy_o[1]  = upd_b.upd_pos_y;
  assign udir_o[1] = upd_b.upd_dir;
  assign uspr_o[1] = upd_b.upd_sprite;
  assign urst_o[1] = upd_b.upd_rst;

  function automatic logic [10:0] home_x(input int s);
    case (s)
      0: return 11'd1367;
      1: return 11'd1367;
      2: return 11'd1335;
      3: return 11'd1399;
      default: return 11'd1415;
    endcase
  endfunction

  function automatic logic [9:0] home_y(input int s);
    case (s)
      0: return 10'd306;
      1, 2, 3: return 10'd146;
      default: return 10'd66;
    endcase
  endfunction

  // One step of movement; invalid directions leave the sprite where it is.
  function automatic logic [20:0] move(input logic [10:0] x, input logic [9:0] y, input logic [3:0] d);
    case (d)
      4'b0001: x = x + 11'd16;
      4'b0010: y = y - 10'd16;
      4'b0100: y = y + 10'd16;
      4'b1000: x = x - 11'd16;
      default: ;
    endcase
    return {x, y};
  endfunction

  function automatic logic [20:0] stage_f(input logic r, input logic [2:0] s, input logic [10:0] x,
                                          input logic [9:0] y, input logic [3:0] d);
    if (r) return {home_x(int'(s)), home_y(int'(s))};
    return move(x, y, d);
  endfunction

  always_ff @(posedge clk) begin
    {upd_a.upd_new_x, upd_a.upd_new_y} <= stage_f(upd_a.upd_rst, upd_a.upd_sprite,
                                                  upd_a.upd_pos_x, upd_a.upd_pos_y, upd_a.upd_dir);
    {upd_b.upd_new_x, upd_b.upd_new_y} <= stage_f(upd_b.upd_rst, upd_b.upd_sprite,
                                                  upd_b.upd_pos_x, upd_b.upd_pos_y, upd_b.upd_dir);
  end

  int          cyc;
  logic [10:0] mx [NI][5];
  logic [9:0]  my [NI][5];
  bit          fr_act [NI];
  int          fr_t [NI];
  logic [3:0]  snap [NI][5];
  bit          ovr_m [NI];
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [3:0]  drv_pac;
  logic [15:0] drv_gh;
  logic        drv_en;
  bit          rand_mode;

  function automatic int td_of(input int m);
    return (m == 0) ? 32 : 10;
  endfunction

  function automatic bit model_busy(input int m, input int c);
    return (c <= 16) || (fr_act[m] && c > fr_t[m] && c <= fr_t[m] + 16);
  endfunction

  function automatic logic [3:0] rand_dir();
    if ($urandom_range(0, 3) == 0) return 4'($urandom);
    return 4'b0001 << $urandom_range(0, 3);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    for (int m = 0; m < NI; m++) begin
      fr_act[m] = 1'b0;
      fr_t[m]   = 0;
      ovr_m[m]  = 1'b0;
      for (int s = 0; s < 5; s++) begin
        mx[m][s]   = '0;
        my[m][s]   = '0;
        snap[m][s] = '0;
      end
    end
  endtask

  task automatic check_outputs();
    for (int m = 0; m < NI; m++) begin
      bit          in_frame;
      bit          done_exp;
      int          k;
      logic [54:0] ex;
      logic [49:0] ey;
      if (cyc == 16)
        for (int s = 0; s < 5; s++) begin
          mx[m][s] = home_x(s);
          my[m][s] = home_y(s);
        end
      done_exp = (cyc == 16) || (fr_act[m] && cyc == fr_t[m] + 16);
      if (fr_act[m] && cyc == fr_t[m] + 16) begin
        for (int s = 0; s < 5; s++)
          {mx[m][s], my[m][s]} = move(mx[m][s], my[m][s], snap[m][s]);
        $display("[TB] inst %0d frame from tick %0d done at cycle %0d", m, fr_t[m], cyc);
      end
      in_frame = fr_act[m] && cyc > fr_t[m] && cyc <= fr_t[m] + 15;
      check_eq($sformatf("busy[%0d]", m), busy_o[m], model_busy(m, cyc));
      check_eq($sformatf("frame_done[%0d]", m), done_o[m], done_exp);
      check_eq($sformatf("pos_valid[%0d]", m), valid_o[m], cyc >= 16);
      check_eq($sformatf("upd_rst[%0d]", m), urst_o[m], cyc <= 15);
      check_eq($sformatf("tick_overrun[%0d]", m), ovr_o[m], ovr_m[m]);
      if (cyc >= 1 && cyc <= 15) begin
        k = (cyc - 1) / 3;
        check_eq($sformatf("init_sprite[%0d]", m), uspr_o[m], k);
        check_eq($sformatf("init_dir[%0d]", m), udir_o[m], 0);
      end
      if (in_frame) begin
        k = (cyc - fr_t[m] - 1) / 3;
        check_eq($sformatf("slot_sprite[%0d]", m), uspr_o[m], k);
        check_eq($sformatf("slot_dir[%0d]", m), udir_o[m], snap[m][k]);
        check_eq($sformatf("slot_pos_x[%0d]", m), upx_o[m], mx[m][k]);
        check_eq($sformatf("slot_pos_y[%0d]", m), upy_o[m], my[m][k]);
      end
      if (!model_busy(m, cyc) || done_exp || cyc == 0) begin
        for (int s = 0; s < 5; s++) begin
          ex[11*s +: 11] = mx[m][s];
          ey[10*s +: 10] = my[m][s];
        end
        check_eq($sformatf("pos_x[%0d]", m), pos_x_o[m], ex);
        check_eq($sformatf("pos_y[%0d]", m), pos_y_o[m], ey);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    if (rand_mode) begin
      drv_pac = rand_dir();
      drv_gh  = {rand_dir(), rand_dir(), rand_dir(), rand_dir()};
      drv_en  = ($urandom_range(0, 7) != 0);
    end
    rst        = 1'b0;
    enable     = drv_en;
    dir_pacman = drv_pac;
    dir_ghosts = drv_gh;
    for (int m = 0; m < NI; m++) begin
      if (cyc % td_of(m) == td_of(m) - 1) begin
        if (model_busy(m, cyc)) begin
          ovr_m[m] = 1'b1;
        end else if (drv_en) begin
          fr_act[m]  = 1'b1;
          fr_t[m]    = cyc;
          snap[m][0] = drv_pac;
          for (int s = 1; s < 5; s++) snap[m][s] = drv_gh[4*(s-1) +: 4];
        end
      end
    end
    cyc++;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) begin
      @(negedge clk);
      for (int m = 0; m < NI; m++) begin
        check_eq($sformatf("rst_pos_x[%0d]", m), pos_x_o[m], 0);
        check_eq($sformatf("rst_pos_y[%0d]", m), pos_y_o[m], 0);
        check_eq($sformatf("rst_valid[%0d]", m), valid_o[m], 0);
        check_eq($sformatf("rst_done[%0d]", m), done_o[m], 0);
        check_eq($sformatf("rst_overrun[%0d]", m), ovr_o[m], 0);
        check_eq($sformatf("rst_upd_rst[%0d]", m), urst_o[m], 1);
        check_eq($sformatf("rst_sprite[%0d]", m), uspr_o[m], 0);
        check_eq($sformatf("rst_dir[%0d]", m), udir_o[m], 0);
        check_eq($sformatf("rst_upd_pos[%0d]", m), {upx_o[m], upy_o[m]}, 0);
        check_eq($sformatf("rst_busy[%0d]", m), busy_o[m], 1);
      end
    end
    model_reset();
  endtask

  initial begin
    int guard;
    rst        = 1'b1;
    enable     = 1'b0;
    dir_pacman = '0;
    dir_ghosts = '0;
    drv_en     = 1'b1;
    drv_pac    = 4'b0001;
    drv_gh     = '0;
    rand_mode  = 1'b0;
    model_reset();
    do_reset(3);

    while (cyc < 17) step();
    check_eq("init_pacman_x", pos_x_o[0][10:0], 11'd1367);
    check_eq("init_pacman_y", pos_y_o[0][9:0], 10'd306);
    check_eq("init_clyde_x", pos_x_o[0][54:44], 11'd1415);
    check_eq("init_clyde_y", pos_y_o[0][49:40], 10'd66);

    while (cyc < 49) step();
    check_eq("move_pacman_x", pos_x_o[0][10:0], 11'd1383);
    check_eq("move_pacman_y", pos_y_o[0][9:0], 10'd306);
    check_eq("move_ghosts_x", pos_x_o[0][54:11], {11'd1415, 11'd1399, 11'd1335, 11'd1367});
    check_eq("move_ghosts_y", pos_y_o[0][49:10], {10'd66, 10'd146, 10'd146, 10'd146});

    // Tick lands at cycle 63; the direction flips three cycles into the frame.
    while (cyc < 66) step();
    drv_pac = 4'b1000;
    while (cyc < 82) step();
    check_eq("snapshot_pacman_x", pos_x_o[0][10:0], 11'd1399);

    drv_en = 1'b0;
    repeat (100) step();
    check_eq("disabled_busy", busy_o[0], 1'b0);
    check_eq("disabled_pacman_x", pos_x_o[0][10:0], 11'd1399);

    rand_mode = 1'b1;
    repeat (600) step();

    rand_mode = 1'b0;
    drv_en    = 1'b1;
    guard     = 0;
    while (!(fr_act[0] && cyc == fr_t[0] + 4) && guard < 100) begin
      step();
      guard++;
    end
    check_eq("frame_wait_in_budget", guard < 100, 1'b1);
    do_reset(2);
    drv_en = 1'b0;
    repeat (20) step();
    check_eq("reinit_pacman_x", pos_x_o[0][10:0], 11'd1367);
    check_eq("reinit_clyde_x", pos_x_o[0][54:44], 11'd1415);
    check_eq("reinit_clyde_y", pos_y_o[0][49:40], 10'd66);
    check_eq("reinit_valid", valid_o[0], 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
